muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/div_iter.sv | 30 +++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V M-extension definitions for the multiply/divide unit.
//   mul_op_t      - operation select presented with a request (M_NONE = no request)
//   is_mul_op     - true for the multiply family
//   is_w_op       - true for the 32-bit "W" variants (result sign-extended to XLEN)
//   is_rem_op     - true for operations returning the remainder
//   is_signed_div - true for divide/remainder operations on signed operands
package riscv_pkg;

  typedef enum logic [3:0] {
    M_NONE = 4'd0,
    M_MUL,
    M_MULH,
    M_MULHSU,
    M_MULHU,
    M_MULW,
    M_DIV,
    M_DIVU,
    M_REM,
    M_REMU,
    M_DIVW,
    M_DIVUW,
    M_REMW,
    M_REMUW
  } mul_op_t;

  function automatic logic is_mul_op(input mul_op_t op);
    return op inside {M_MUL, M_MULH, M_MULHSU, M_MULHU, M_MULW};
  endfunction

  function automatic logic is_w_op(input mul_op_t op);
    return op inside {M_MULW, M_DIVW, M_DIVUW, M_REMW, M_REMUW};
  endfunction

  function automatic logic is_rem_op(input mul_op_t op);
    return op inside {M_REM, M_REMU, M_REMW, M_REMUW};
  endfunction

  function automatic logic is_signed_div(input mul_op_t op);
    return op inside {M_DIV, M_REM, M_DIVW, M_REMW};
  endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: one step of unsigned restoring division.
//   rem     - partial remainder (always < dvs on entry)
//   quo     - dividend bits still to consume in the MSBs, quotient bits in the LSBs
//   dvs     - divisor magnitude
//   rem_nxt - partial remainder after this step
//   quo_nxt - quo shifted left by one with the new quotient bit in bit 0
module div_iter #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  // The extra top bit of diff acts as the borrow: set when shifted < dvs.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    fits    = ~diff[XLEN];
    rem_nxt = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension multiply/divide unit.
//   clk, rst_n       - rising-edge clock, asynchronous active-low reset
//   start_i, op_i    - request valid and operation, sampled only in IDLE
//   op_a_i, op_b_i   - rs1 / rs2 operands
//   kill_i           - pipeline flush: abandon any operation, back to IDLE
//   result_o         - registered result, held until the next completion
//   done_o           - one-cycle result-valid pulse (DONE state)
//   stall_o          - pipeline freeze while an operation is accepted/running
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  mul_op_t         op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            kill_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            stall_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state_q;
  mul_op_t         op_q;
  logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, dvs_q, result_q;
  logic            quo_neg_q, rem_neg_q, done_q;
  logic [CW-1:0]   cnt_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic signed [31:0] t;
    t = signed'(x);
    return XLEN'(t);
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Request decode and divide set-up, evaluated on the live inputs.
  logic            w_in, sgn_in, op_ok, accept, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_eff, b_eff, mag_a, mag_b, quo_init, min_val, dividend, bypass_res;

  always_comb begin
    w_in   = is_w_op(op_i);
    sgn_in = is_signed_div(op_i);
    op_ok  = (op_i != M_NONE) && !((XLEN == 32) && w_in);
    accept = (state_q == S_IDLE) && start_i && op_ok && !kill_i;
    a_eff  = op_a_i;
    b_eff  = op_b_i;
    if (w_in) begin
      a_eff = sgn_in ? sext32(op_a_i[31:0]) : XLEN'(op_a_i[31:0]);
      b_eff = sgn_in ? sext32(op_b_i[31:0]) : XLEN'(op_b_i[31:0]);
    end
    a_neg    = sgn_in && a_eff[XLEN-1];
    b_neg    = sgn_in && b_eff[XLEN-1];
    mag_a    = apply_sign(a_eff, a_neg);
    mag_b    = apply_sign(b_eff, b_neg);
    // W divides run 32 steps, so park the dividend in the top half.
    quo_init = w_in ? (mag_a << (XLEN - 32)) : mag_a;
    min_val  = w_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    dividend = w_in ? sext32(op_a_i[31:0]) : op_a_i;
    div0     = (b_eff == '0);
    ovf      = sgn_in && (a_eff == min_val) && (b_eff == '1);
    if (div0) bypass_res = is_rem_op(op_i) ? dividend : '1;
    else      bypass_res = is_rem_op(op_i) ? '0 : dividend;
  end

  // Multiply on latched operands; one extra sign bit covers signed/unsigned mixes.
  logic                   a_sx, b_sx;
  logic signed [XLEN:0]   ma_ext, mb_ext;
  logic signed [PW-1:0]   ma_w, mb_w, prod;
  logic        [XLEN-1:0] mul_res;

  always_comb begin
    a_sx   = (op_q == M_MULH || op_q == M_MULHSU) && a_q[XLEN-1];
    b_sx   = (op_q == M_MULH) && b_q[XLEN-1];
    ma_ext = signed'({a_sx, a_q});
    mb_ext = signed'({b_sx, b_q});
    ma_w   = PW'(ma_ext);
    mb_w   = PW'(mb_ext);
    prod   = ma_w * mb_w;
    case (op_q)
      M_MULW:                    mul_res = sext32(prod[31:0]);
      M_MULH, M_MULHSU, M_MULHU: mul_res = prod[PW-1:XLEN];
      default:                   mul_res = prod[XLEN-1:0];
    endcase
  end

  logic [XLEN-1:0] rem_nxt, quo_nxt, div_sel, div_res;

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Sign fix-up of the final step's outputs, registered on entry to DONE.
  always_comb begin
    div_sel = is_rem_op(op_q) ? apply_sign(rem_nxt, rem_neg_q) : apply_sign(quo_nxt, quo_neg_q);
    div_res = is_w_op(op_q) ? sext32(div_sel[31:0]) : div_sel;
  end

  assign stall_o  = rst_n && (accept || state_q == S_MUL || state_q == S_DIV);
  assign result_o = result_q;
  assign done_o   = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= M_NONE;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              op_q      <= op_i;
              a_q       <= op_a_i;
              b_q       <= op_b_i;
              rem_q     <= '0;
              quo_q     <= quo_init;
              dvs_q     <= mag_b;
              quo_neg_q <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              if (is_mul_op(op_i)) begin
                state_q <= S_MUL;
                cnt_q   <= CW'(MUL_LAT);
              end else if (div0 || ovf) begin
                state_q  <= S_DONE;
                result_q <= bypass_res;
                done_q   <= 1'b1;
              end else begin
                state_q <= S_DIV;
                cnt_q   <= w_in ? CW'(32) : CW'(XLEN);
              end
            end
          end
          S_MUL: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              state_q  <= S_DONE;
              result_q <= mul_res;
              done_q   <= 1'b1;
            end
          end
          S_DIV: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              state_q  <= S_DONE;
              result_q <= div_res;
              done_q   <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit (XLEN=64, MUL_LAT=2).
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  mul_op_t     op_i = M_NONE;
  logic [63:0] op_a_i = '0;
  logic [63:0] op_b_i = '0;
  logic [63:0] result_o;
  logic        done_o;
  logic        stall_o;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64), .MUL_LAT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .kill_i   (kill_i),
    .result_o (result_o),
    .done_o   (done_o),
    .stall_o  (stall_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    mul_op_t     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input mul_op_t op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] res, input int cyc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.cyc = cyc;
    vecs.push_back(v);
  endtask

  // Presents a request as cycle 0 and watches `budget` further cycles.
  // start_i stays high until done_o is seen; kill_at >= 1 pulses kill_i in that cycle.
  task automatic run_op(input mul_op_t op, input logic [63:0] a, input logic [63:0] b,
                        input int kill_at, input int budget,
                        output int done_cyc, output logic [63:0] res,
                        output int stall_cnt, output int stall_last, output int done_cnt);
    @(negedge clk);
    op_i = op; op_a_i = a; op_b_i = b; start_i = 1'b1;
    done_cyc = -1; res = '0; stall_cnt = 0; stall_last = -1; done_cnt = 0;
    #1;
    if (stall_o) begin stall_cnt++; stall_last = 0; end
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      kill_i = 1'b0;
      if (stall_o) begin stall_cnt++; stall_last = cyc; end
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; res = result_o; end
        start_i = 1'b0; op_i = M_NONE;
      end
      if (cyc == kill_at) begin kill_i = 1'b1; start_i = 1'b0; op_i = M_NONE; end
    end
    kill_i = 1'b0; start_i = 1'b0; op_i = M_NONE;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          dc, sc, sl, dn;
    logic [63:0] res;
    logic [63:0] last_res;

    add(M_MUL,    64'd7,                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 3);
    add(M_DIV,    64'hFFFF_FFFF_FFFF_FFEC, 64'd6,                  64'hFFFF_FFFF_FFFF_FFFD, 65);
    add(M_REM,    64'hFFFF_FFFF_FFFF_FFEC, 64'd6,                  64'hFFFF_FFFF_FFFF_FFFE, 65);
    add(M_DIV,    64'd20,                 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add(M_REM,    64'd20,                 64'hFFFF_FFFF_FFFF_FFFA, 64'd2,                  65);
    add(M_DIVU,   64'd100,                64'd7,                  64'd14,                 65);
    add(M_REMU,   64'd100,                64'd7,                  64'd2,                  65);
    add(M_DIVU,   64'd5,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1);
    add(M_REMU,   64'd5,                  64'd0,                  64'd5,                  1);
    add(M_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    add(M_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  1);
    add(M_DIVW,   64'h0000_0001_8000_0000, 64'd2,                  64'hFFFF_FFFF_C000_0000, 33);
    add(M_REMW,   64'h1234_5678_FFFF_FFF9, 64'd3,                  64'hFFFF_FFFF_FFFF_FFFF, 33);
    add(M_DIVUW,  64'h0000_0000_8000_0000, 64'd1,                  64'hFFFF_FFFF_8000_0000, 33);
    add(M_DIVW,   64'd5,                  64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add(M_DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    add(M_MULH,   64'h8000_0000_0000_0000, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 3);
    add(M_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 3);
    add(M_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'd1,                  3);
    add(M_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFE, 3);

    // Reset state, with a request presented during reset.
    start_i = 1'b1; op_i = M_MUL; op_a_i = 64'd3; op_b_i = 64'd3;
    #12;
    check_int("reset_stall", int'(stall_o), 0);
    check_int("reset_done", int'(done_o), 0);
    check64("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; start_i = 1'b0; op_i = M_NONE;

    // start_i with M_NONE is not a request.
    run_op(M_NONE, 64'd1, 64'd2, -1, 5, dc, res, sc, sl, dn);
    check_int("none_stall_cnt", sc, 0);
    check_int("none_done_cnt", dn, 0);

    last_res = '0;
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, vecs[i].cyc + 3, dc, res, sc, sl, dn);
      check_int($sformatf("vec%0d_%s_done_cycle", i, vecs[i].op.name()), dc, vecs[i].cyc);
      check64($sformatf("vec%0d_%s_result", i, vecs[i].op.name()), res, vecs[i].res);
      check_int($sformatf("vec%0d_%s_done_pulses", i, vecs[i].op.name()), dn, 1);
      check_int($sformatf("vec%0d_%s_stall_cycles", i, vecs[i].op.name()), sc, vecs[i].cyc);
      check_int($sformatf("vec%0d_%s_stall_last", i, vecs[i].op.name()), sl, vecs[i].cyc - 1);
      check64($sformatf("vec%0d_%s_result_hold", i, vecs[i].op.name()), result_o, vecs[i].res);
      last_res = vecs[i].res;
    end

    // Kill in cycle 10 of a divide: IDLE in cycle 11, no done, result kept.
    run_op(M_DIV, 64'd100, 64'd7, 10, 80, dc, res, sc, sl, dn);
    check_int("kill_done_pulses", dn, 0);
    check_int("kill_stall_cycles", sc, 11);
    check_int("kill_stall_last", sl, 10);
    check64("kill_result_kept", result_o, last_res);

    run_op(M_MULHU, 64'h8000_0000_0000_0000, 64'd4, -1, 6, dc, res, sc, sl, dn);
    check_int("post_kill_mulhu_cycle", dc, 3);
    check64("post_kill_mulhu_result", res, 64'd2);
    check_int("post_kill_mulhu_pulses", dn, 1);

    // Reset mid-divide: immediate clear, no completion afterwards.
    @(negedge clk);
    op_i = M_DIV; op_a_i = 64'd100; op_b_i = 64'd7; start_i = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check64("midop_reset_result", result_o, 64'd0);
    check_int("midop_reset_stall", int'(stall_o), 0);
    check_int("midop_reset_done", int'(done_o), 0);
    @(negedge clk);
    start_i = 1'b0; op_i = M_NONE; rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done_o) dn++;
    end
    check_int("midop_reset_no_done", dn, 0);
    check64("midop_reset_result_after", result_o, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
